// File: rtl/imsic_msi_issue.sv
// MSI issue stage: filters setipnum writes, queues legal ones and replays each as a
// fixed-width valid pulse followed by an info hold window. Optional drop counter: IMSIC_MSI_DROP_CNT_EN.
module imsic_msi_issue #(
  parameter int NR_INTP_FILES  = 7,
  parameter int NR_HARTS       = 4,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_SRC         = 32,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int FIFO_DEPTH     = 4,
  parameter int VLD_HIGH       = 4,
  parameter int INFO_HOLD      = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_wr_vld,
  output logic                           o_wr_rdy,
  input  logic [NR_HARTS_WIDTH-1:0]      i_wr_hart,
  input  logic [$clog2(NR_INTP_FILES)-1:0] i_wr_file,
  input  logic [31:0]                    i_wr_data,
  output logic [MSI_INFO_WIDTH-1:0]      o_msi_info,
  output logic                           o_msi_info_vld,
  output logic                           o_busy
`ifdef IMSIC_MSI_DROP_CNT_EN
  ,
  output logic [15:0]                    o_drop_cnt
`endif
);

  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC);
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES);
  localparam int AW              = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX         = (VLD_HIGH > INFO_HOLD) ? VLD_HIGH : INFO_HOLD;
  localparam int CNT_W           = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  if (MSI_INFO_WIDTH < NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH) begin : g_chk_width
    $error("MSI_INFO_WIDTH too small for hart/file/identity fields");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (VLD_HIGH < 1 || INFO_HOLD < 1) begin : g_chk_timing
    $error("VLD_HIGH and INFO_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  logic [MSI_INFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic                      fifo_full, fifo_empty;
  logic                      accept, legal, push, pop;
  logic                      hart_ok, file_ok, data_ok;
  logic [MSI_INFO_WIDTH-1:0] wr_info;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [MSI_INFO_WIDTH-1:0] info_q;
  logic                      vld_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign o_wr_rdy = ~fifo_full;
  assign accept   = i_wr_vld & ~fifo_full;

  assign hart_ok = int'(i_wr_hart) < NR_HARTS;
  assign file_ok = int'(i_wr_file) < NR_INTP_FILES;
  assign data_ok = (i_wr_data != '0) && (i_wr_data < $unsigned(NR_SRC));
  assign legal   = hart_ok & file_ok & data_ok;
  assign push    = accept & legal;
  assign pop     = (state_q == S_IDLE) && !fifo_empty;

  always_comb begin
    wr_info = '0;
    wr_info[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH] = i_wr_hart;
    wr_info[NR_SRC_WIDTH +: INTP_FILE_WIDTH]    = i_wr_file;
    wr_info[NR_SRC_WIDTH-1:0]                   = i_wr_data[NR_SRC_WIDTH-1:0];
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_info;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      info_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            info_q  <= mem_q[rd_ptr_q[AW-1:0]];
            vld_q   <= 1'b1;
            cnt_q   <= CNT_W'(VLD_HIGH - 1);
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            vld_q   <= 1'b0;
            cnt_q   <= CNT_W'(INFO_HOLD - 1);
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_HOLD: begin
          // info_q is deliberately left alone so the gate can sample it late.
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_msi_info     = info_q;
  assign o_msi_info_vld = vld_q;
  assign o_busy         = ~fifo_empty | (state_q != S_IDLE);

`ifdef IMSIC_MSI_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !legal && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_imsic_msi_issue.sv
// Directed bench for imsic_msi_issue: a scoreboard queue holds expected MSI info per legal
// write; a negedge monitor pops it on each valid rise and checks pulse width and info hold.
module tb_imsic_msi_issue;

  logic        clk;
  logic        rstn;
  logic        i_wr_vld;
  logic        o_wr_rdy;
  logic [1:0]  i_wr_hart;
  logic [2:0]  i_wr_file;
  logic [31:0] i_wr_data;
  logic [16:0] o_msi_info;
  logic        o_msi_info_vld;
  logic        o_busy;
`ifdef IMSIC_MSI_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  imsic_msi_issue #(.NR_HARTS(3)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_wr_vld       (i_wr_vld),
    .o_wr_rdy       (o_wr_rdy),
    .i_wr_hart      (i_wr_hart),
    .i_wr_file      (i_wr_file),
    .i_wr_data      (i_wr_data),
    .o_msi_info     (o_msi_info),
    .o_msi_info_vld (o_msi_info_vld),
    .o_busy         (o_busy)
`ifdef IMSIC_MSI_DROP_CNT_EN
    ,
    .o_drop_cnt     (o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q [$];
  int          rise_cyc [$];
  int          pulses = 0;
  int          cyc = 0;
  logic        prev_vld = 1'b0;
  int          width = 0;
  int          stab = 0;
  logic [16:0] cap = '0;
  int          stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference legality and packing, written against NR_HARTS=3 used above.
  task automatic wr(input logic [1:0] h, input logic [2:0] f, input logic [31:0] d);
    int n;
    i_wr_vld  = 1'b1;
    i_wr_hart = h;
    i_wr_file = f;
    i_wr_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_wr_rdy) break;
      stalls++;
      n++;
      if (n > 200) begin
        chk("wr_accept_timeout", 32'(o_wr_rdy), 32'd1);
        i_wr_vld = 1'b0;
        return;
      end
    end
    if (h < 2'd3 && f < 3'd7 && d != 32'd0 && d < 32'd32)
      exp_q.push_back({h, 7'd0, f, d[4:0]});
    @(posedge clk);
    #1;
    i_wr_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((o_busy || o_msi_info_vld) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(o_busy), 32'd0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      prev_vld = 1'b0;
      width    = 0;
      stab     = 0;
    end else begin
      if (stab > 0) begin
        chk("info_stable", 32'(o_msi_info), 32'(cap));
        stab--;
      end
      if (o_msi_info_vld && !prev_vld) begin
        pulses++;
        rise_cyc.push_back(cyc);
        width = 0;
        chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("pulse_info", 32'(o_msi_info), 32'(exp_q.pop_front()));
        cap  = o_msi_info;
        stab = 12;
      end
      if (o_msi_info_vld) width++;
      if (!o_msi_info_vld && prev_vld) chk("pulse_width", 32'(width), 32'd4);
      prev_vld = o_msi_info_vld;
    end
  end

  initial begin
    int p0;
    int r0;
    i_wr_vld  = 1'b0;
    i_wr_hart = '0;
    i_wr_file = '0;
    i_wr_data = '0;
    rstn      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy",  32'(o_wr_rdy), 32'd1);
    chk("rst_info", 32'(o_msi_info), 32'd0);
    chk("rst_vld",  32'(o_msi_info_vld), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
`ifdef IMSIC_MSI_DROP_CNT_EN
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
`endif
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single write: latency, info packing, busy timing
    wr(2'd1, 3'd2, 32'd5);
    chk("single_vld_e0", 32'(o_msi_info_vld), 32'd0);
    chk("single_busy_e0", 32'(o_busy), 32'd1);
    @(posedge clk);
    #1;
    chk("single_vld_e1", 32'(o_msi_info_vld), 32'd1);
    chk("single_info_e1", 32'(o_msi_info), 32'({2'b01, 7'd0, 3'd2, 5'd5}));
    repeat (11) @(posedge clk);
    #1;
    chk("single_busy_e12", 32'(o_busy), 32'd1);
    chk("single_info_e12", 32'(o_msi_info), 32'({2'b01, 7'd0, 3'd2, 5'd5}));
    @(posedge clk);
    #1;
    chk("single_busy_e13", 32'(o_busy), 32'd0);
    chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back: rises 13 cycles apart, FIFO order
    p0 = pulses;
    r0 = rise_cyc.size();
    wr(2'd1, 3'd0, 32'd1);
    wr(2'd2, 3'd6, 32'd31);
    wr(2'd0, 3'd1, 32'd17);
    wait_idle("b2b_idle", 100);
    chk("b2b_pulses", 32'(pulses - p0), 32'd3);
    if (rise_cyc.size() >= r0 + 3) begin
      chk("b2b_gap1", 32'(rise_cyc[r0 + 1] - rise_cyc[r0]), 32'd13);
      chk("b2b_gap2", 32'(rise_cyc[r0 + 2] - rise_cyc[r0 + 1]), 32'd13);
    end
    chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: six writes into a four-deep FIFO
    p0 = pulses;
    stalls = 0;
    for (int i = 0; i < 6; i++) wr(2'(i % 3), 3'(i), 32'(i + 3));
    chk("bp_stalled", 32'(stalls > 0), 32'd1);
    wait_idle("bp_idle", 200);
    chk("bp_pulses", 32'(pulses - p0), 32'd6);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_rdy", 32'(o_wr_rdy), 32'd1);

    // Illegal writes are dropped
    p0 = pulses;
    wr(2'd0, 3'd0, 32'd0);
    wr(2'd0, 3'd0, 32'd32);
    wr(2'd0, 3'd7, 32'd5);
    wr(2'd3, 3'd0, 32'd5);
    repeat (20) @(posedge clk);
    #1;
    chk("illegal_no_pulse", 32'(pulses - p0), 32'd0);
    chk("illegal_busy", 32'(o_busy), 32'd0);
`ifdef IMSIC_MSI_DROP_CNT_EN
    chk("illegal_drop_cnt", 32'(o_drop_cnt), 32'd4);
`endif

    // Reset mid-pulse with two MSIs still queued
    wr(2'd2, 3'd3, 32'd9);
    wr(2'd1, 3'd4, 32'd10);
    wr(2'd0, 3'd5, 32'd11);
    chk("rstmid_vld_before", 32'(o_msi_info_vld), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstmid_vld_async", 32'(o_msi_info_vld), 32'd0);
    chk("rstmid_info_async", 32'(o_msi_info), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    p0 = pulses;
    repeat (30) @(posedge clk);
    #1;
    chk("rstmid_no_pulse", 32'(pulses - p0), 32'd0);
    chk("rstmid_rdy", 32'(o_wr_rdy), 32'd1);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
`ifdef IMSIC_MSI_DROP_CNT_EN
    chk("rstmid_drop_clr", 32'(o_drop_cnt), 32'd0);

    // Drop counter saturation
    i_wr_hart = '0;
    i_wr_file = '0;
    i_wr_data = 32'd0;
    i_wr_vld  = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    i_wr_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_saturate", 32'(o_drop_cnt), 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imsic_msi_issue.md
# imsic_msi_issue

Bus-clock-domain MSI issue stage that sits directly upstream of the IMSIC CSR gate. It accepts setipnum writes (hart, interrupt file, identity), filters illegal ones, and buffers legal ones in a small FIFO. It then replays them one at a time as a packed `o_msi_info` word with an `o_msi_info_vld` pulse, timed so the downstream gate can synchronize the valid level and capture the info on its falling edge.

## Interface
- `NR_INTP_FILES`, 7, interrupt files per hart (M, S, VS…).
- `NR_HARTS`, 4, harts served.
- `NR_HARTS_WIDTH`, 2, hart ID width.
- `NR_SRC`, 32, interrupt identities per file; legal IDs are 1..`NR_SRC`-1.
- `MSI_INFO_WIDTH`, 17, packed info width. Must be ≥ `NR_HARTS_WIDTH` + `INTP_FILE_WIDTH` + `NR_SRC_WIDTH`.
- `FIFO_DEPTH`, 4, buffered MSIs; power of two, ≥ 2.
- `VLD_HIGH`, 4, cycles `o_msi_info_vld` is held high per MSI; ≥ 1.
- `INFO_HOLD`, 8, cycles `o_msi_info` stays stable after `o_msi_info_vld` falls; ≥ 1.
- Derived: `NR_SRC_WIDTH` = clog2(`NR_SRC`); `INTP_FILE_WIDTH` = clog2(`NR_INTP_FILES`).

Ports:
- `clk`, input, 1: the single clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `i_wr_vld`, input, 1: setipnum write request.
- `o_wr_rdy`, output, 1: write accepted when both `i_wr_vld` and `o_wr_rdy` are high.
- `i_wr_hart`, input, `NR_HARTS_WIDTH`: target hart.
- `i_wr_file`, input, `INTP_FILE_WIDTH`: target interrupt file (0 = M, 1 = S, 2+ = VS).
- `i_wr_data`, input, 32: setipnum value written.
- `o_msi_info`, output, `MSI_INFO_WIDTH`: packed MSI.
  - `[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH]` = hart.
  - `[NR_SRC_WIDTH +: INTP_FILE_WIDTH]` = file.
  - `[NR_SRC_WIDTH-1:0]` = identity.
  - All other bits are 0.
- `o_msi_info_vld`, output, 1: issue pulse; downstream acts on its falling edge.
- `o_busy`, output, 1: FIFO non-empty or FSM not IDLE.

## Operation
- **Accept:** `o_wr_rdy` = FIFO not full. It is registered-state derived; it is not combinationally dependent on `i_wr_vld`.
- **Legality:** an accepted write is legal iff all of the following hold:
  - `i_wr_hart` < `NR_HARTS`
  - `i_wr_file` < `NR_INTP_FILES`
  - `i_wr_data` != 0
  - `i_wr_data` < `NR_SRC`

  Legal writes push {hart, file, `i_wr_data[NR_SRC_WIDTH-1:0]`} into the FIFO. Illegal writes are consumed and discarded.
- **FIFO:** circular, with read/write pointers one bit wider than the index. Full means the index bits are equal and the MSBs differ.
- **FSM states:**
  - **IDLE:** if the FIFO is non-empty, pop the head, load `o_msi_info`, set `o_msi_info_vld`=1, load the counter with `VLD_HIGH`-1, and go to HIGH.
  - **HIGH:** count down; at 0, clear `o_msi_info_vld`, load the counter with `INFO_HOLD`-1, and go to HOLD.
  - **HOLD:** `o_msi_info` is unchanged; count down; at 0, go to IDLE.
- `o_msi_info` changes only on the IDLE→HIGH transition.
- **Simultaneous push and pop:** allowed. When full, the pop does not open a slot in the same cycle, because `o_wr_rdy` is already low.

## Timing
- **Reset values:**
  - `o_wr_rdy`=1, `o_msi_info`=0, `o_msi_info_vld`=0, `o_busy`=0.
  - FIFO empty, FSM in IDLE.
- **Latency:** a legal write accepted at edge E0 with the FSM in IDLE and the FIFO empty raises `o_msi_info_vld` (and presents info) at E1.
- **Pulse shape:** `o_msi_info_vld` is high for exactly `VLD_HIGH` cycles. Info is stable from E1 through `VLD_HIGH`+`INFO_HOLD` cycles.
- **Spacing:** the next pulse rises no earlier than E1+`VLD_HIGH`+`INFO_HOLD`+1 (one IDLE cycle between MSIs). Throughput is one MSI per `VLD_HIGH`+`INFO_HOLD`+1 cycles.
- **Reset mid-issue:** `rstn` low clears `o_msi_info_vld` and `o_msi_info` asynchronously and discards FIFO contents. No partial pulse resumes after reset.

## Configuration
- **`IMSIC_MSI_DROP_CNT_EN`**
  - **Defined:** adds output `o_drop_cnt` [15:0]. It is reset to 0, increments by 1 on every accepted illegal write, saturates at 16'hFFFF, and is cleared only by reset.
  - **Undefined:** the port and the counter are absent; illegal writes are silently discarded.

## Test plan
- **Single write:** hart=1, file=2, data=5 at E0 → at E1, `o_msi_info` has top bits=2'b01, `[7:5]`=3'd2, `[4:0]`=5'd5, and `o_msi_info_vld`=1 for 4 cycles. Info is stable through E1+12; `o_busy` falls after HOLD.
- **Back-to-back:** 3 legal writes on consecutive cycles → three pulses, rising edges 13 cycles apart, in FIFO order, each with its own info.
- **Backpressure:** 6 writes with the FSM busy (`FIFO_DEPTH`=4) → `o_wr_rdy` drops after the FIFO fills and rises when the FSM pops. All writes are issued in order and none are lost.
- **Illegal filtering:** data=0, data=32, file=7, hart=3 with `NR_HARTS`=3 → no pulse. With `IMSIC_MSI_DROP_CNT_EN`, `o_drop_cnt`=4.
- **Reset mid-pulse:** assert `rstn` during HIGH with 2 MSIs queued → `o_msi_info_vld` goes to 0 immediately. After release there is no pulse and `o_wr_rdy`=1.
- **Counter saturation** (macro defined): 65537 illegal writes → `o_drop_cnt` holds 16'hFFFF.
